// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, stream geometry
// and the running-checksum helper.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_WIDTH     = 8;
  localparam int WORD_WIDTH     = BYTES_PER_WORD * BYTE_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Modulo-256 accumulation used by the image checksum.
  function automatic logic [BYTE_WIDTH-1:0] csum_add(input logic [BYTE_WIDTH-1:0] acc,
                                                     input logic [BYTE_WIDTH-1:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: collects four stream bytes little-endian into one 32-bit word
// and strobes word_ready_o combinationally on the byte that completes it.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  byte_en_i,
  input  logic [BYTE_WIDTH-1:0] byte_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  word_ready_o
);

  logic [1:0]            cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;

  // Byte lane select and counter advance.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d  = 2'd0;
      word_d = {WORD_WIDTH{1'b0}};
    end else if (byte_en_i) begin
      case (cnt_q)
        2'd0:    word_d[7:0]   = byte_i;
        2'd1:    word_d[15:8]  = byte_i;
        2'd2:    word_d[23:16] = byte_i;
        2'd3:    word_d[31:24] = byte_i;
        default: word_d        = word_q;
      endcase
      cnt_d = cnt_q + 2'd1;
    end else begin
      cnt_d  = cnt_q;
      word_d = word_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      word_q <= {WORD_WIDTH{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = byte_en_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a boot image into program memory and holds the core in
// reset until it is complete. PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  output logic                  we_mem_prog_o,
  output logic [ADDR_WIDTH-1:0] addr_mem_prog_o,
  output logic [DATA_WIDTH-1:0] val_mem_prog_write_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  core_rst_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH:0]   MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e TAIL_ST = ST_CHECK;
`else
  localparam state_e TAIL_ST = ST_DONE;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  core_rst_q, core_rst_d;
  logic                  err_next_s;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic                  err_q, err_d;
`endif

  logic [ADDR_WIDTH:0]   len_clamp_s;
  logic [ADDR_WIDTH:0]   cnt_inc_s;
  logic                  pack_clr_s;
  logic                  byte_en_s;
  logic                  word_ready_s;
  logic [WORD_WIDTH-1:0] word_s;

  // Longer images are cut at the memory size so the address never wraps.
  assign len_clamp_s = (len_i > MAX_LEN) ? MAX_LEN : len_i;
  assign cnt_inc_s   = cnt_q + CNT_ONE;
  assign byte_en_s   = byte_valid_i && ready_q && (state_q == ST_LOAD);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (pack_clr_s),
    .byte_en_i    (byte_en_s),
    .byte_i       (byte_i),
    .word_o       (word_s),
    .word_ready_o (word_ready_s)
  );

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    pack_clr_s = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          len_d      = len_clamp_s;
          cnt_d      = LEN_ZERO;
          addr_d     = {ADDR_WIDTH{1'b0}};
          pack_clr_s = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d      = 8'h00;
          err_d      = 1'b0;
`endif
          state_d    = (len_clamp_s == LEN_ZERO) ? TAIL_ST : ST_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (byte_en_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d = csum_add(sum_q, byte_i);
`endif
          state_d = word_ready_s ? ST_WRITE : ST_LOAD;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_inc_s;
        if (cnt_inc_s == len_q) begin
          state_d = TAIL_ST;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = ST_LOAD;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (byte_valid_i && ready_q) begin
          err_d   = (csum_add(sum_q, byte_i) != 8'h00);
          state_d = ST_DONE;
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef PROG_LOADER_CHECKSUM_EN
    err_next_s = err_d;
`else
    err_next_s = 1'b0;
`endif
    ready_d    = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    we_d       = (state_d == ST_WRITE);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
    done_d     = (state_d == ST_DONE);
    core_rst_d = !((state_d == ST_DONE) && !err_next_s);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= LEN_ZERO;
      cnt_q      <= LEN_ZERO;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  assign byte_ready_o         = ready_q;
  assign we_mem_prog_o        = we_q;
  assign addr_mem_prog_o      = addr_q;
  assign val_mem_prog_write_o = word_s;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign core_rst_o           = core_rst_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err_o                = err_q;
`else
  assign err_o                = 1'b0;
`endif

endmodule
